// File: rtl/win_pos_gen.sv
// Window origin generator: raster-scans a window over a frame and emits the
// byte offset of each window origin, computed incrementally without a multiplier.
module win_pos_gen #(
    parameter int DIM_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [31:0]      FrameBase,
    input  logic [DIM_W-1:0] FrameCols,
    input  logic [DIM_W-1:0] FrameRows,
    input  logic [DIM_W-1:0] WinCols,
    input  logic [DIM_W-1:0] WinRows,
    input  logic             PosReady,
    output logic             PosValid,
    output logic [31:0]      add4_out,
    output logic [DIM_W-1:0] WinRow,
    output logic [DIM_W-1:0] WinCol,
    output logic             LastPos,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [DIM_W-1:0] max_col;
    logic [DIM_W-1:0] max_row;
    logic [31:0]      row_step;
    logic [31:0]      row_start;

    logic             cfg_ok;
    logic             at_row_end;
    logic             xfer;
    logic [DIM_W-1:0] nxt_col;
    logic [DIM_W-1:0] nxt_row;
    logic             nxt_last;

    always_comb begin
        cfg_ok     = (WinCols != '0) && (WinRows != '0) &&
                     (WinCols <= FrameCols) && (WinRows <= FrameRows);
        at_row_end = (WinCol == max_col);
        xfer       = PosValid && PosReady;
        nxt_col    = at_row_end ? '0 : WinCol + DIM_W'(1);
        nxt_row    = at_row_end ? WinRow + DIM_W'(1) : WinRow;
        nxt_last   = (nxt_row == max_row) && (nxt_col == max_col);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            max_col   <= '0;
            max_row   <= '0;
            row_step  <= '0;
            row_start <= '0;
            PosValid  <= 1'b0;
            add4_out  <= '0;
            WinRow    <= '0;
            WinCol    <= '0;
            LastPos   <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        max_col   <= FrameCols - WinCols;
                        max_row   <= FrameRows - WinRows;
                        row_step  <= 32'(FrameCols) << 2;
                        row_start <= FrameBase;
                        add4_out  <= FrameBase;
                        WinRow    <= '0;
                        WinCol    <= '0;
                        if (cfg_ok) begin
                            state    <= RUN;
                            PosValid <= 1'b1;
                            Busy     <= 1'b1;
                            Err      <= 1'b0;
                            LastPos  <= (FrameCols == WinCols) && (FrameRows == WinRows);
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (LastPos) begin
                            state    <= DONE;
                            PosValid <= 1'b0;
                            Busy     <= 1'b0;
                            LastPos  <= 1'b0;
                            Done     <= 1'b1;
                        end else begin
                            WinCol  <= nxt_col;
                            WinRow  <= nxt_row;
                            LastPos <= nxt_last;
                            // Row wrap reloads from the row-start register so column steps never accumulate drift.
                            if (at_row_end) begin
                                row_start <= row_start + row_step;
                                add4_out  <= row_start + row_step;
                            end else begin
                                add4_out  <= add4_out + 32'd4;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_win_pos_gen.sv
// Randomized and directed bench for win_pos_gen against a raster-order reference list.
module tb_win_pos_gen;

    localparam int DIM_W = 8;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Start = 1'b0;
    logic [31:0]      FrameBase = '0;
    logic [DIM_W-1:0] FrameCols = '0;
    logic [DIM_W-1:0] FrameRows = '0;
    logic [DIM_W-1:0] WinCols = '0;
    logic [DIM_W-1:0] WinRows = '0;
    logic             PosReady = 1'b0;
    logic             PosValid;
    logic [31:0]      add4_out;
    logic [DIM_W-1:0] WinRow;
    logic [DIM_W-1:0] WinCol;
    logic             LastPos;
    logic             Busy;
    logic             Done;
    logic             Err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    win_pos_gen #(.DIM_W(DIM_W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .FrameBase(FrameBase),
        .FrameCols(FrameCols), .FrameRows(FrameRows),
        .WinCols(WinCols), .WinRows(WinRows), .PosReady(PosReady),
        .PosValid(PosValid), .add4_out(add4_out), .WinRow(WinRow), .WinCol(WinCol),
        .LastPos(LastPos), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".PosValid"}, 32'(PosValid), 0);
        check({tag, ".add4_out"}, add4_out, 0);
        check({tag, ".WinRow"},   32'(WinRow), 0);
        check({tag, ".WinCol"},   32'(WinCol), 0);
        check({tag, ".LastPos"},  32'(LastPos), 0);
        check({tag, ".Busy"},     32'(Busy), 0);
        check({tag, ".Done"},     32'(Done), 0);
        check({tag, ".Err"},      32'(Err), 0);
    endtask

    // mode 0: always ready; 1: random ready/Start/config noise; 2: stall 3 cycles on 2nd position.
    // abort_after > 0: assert Rst once that many transfers have completed.
    task automatic run_scan(input logic [31:0] base, input int unsigned fc, input int unsigned fr,
                            input int unsigned wc, input int unsigned wr,
                            input int mode, input int unsigned abort_after);
        logic [31:0] exp_addr[$];
        int unsigned exp_row[$];
        int unsigned exp_col[$];
        int unsigned idx, cycles, stall, n;
        bit valid_cfg;
        valid_cfg = (wc != 0) && (wr != 0) && (wc <= fc) && (wr <= fr);
        if (valid_cfg) begin
            for (int unsigned r = 0; r <= fr - wr; r++)
                for (int unsigned c = 0; c <= fc - wc; c++) begin
                    exp_addr.push_back(base + 32'(4 * (r * fc + c)));
                    exp_row.push_back(r);
                    exp_col.push_back(c);
                end
        end
        n = exp_addr.size();

        FrameBase = base;
        FrameCols = DIM_W'(fc);
        FrameRows = DIM_W'(fr);
        WinCols   = DIM_W'(wc);
        WinRows   = DIM_W'(wr);
        Start     = 1'b1;
        PosReady  = (mode == 1) ? 1'($urandom) : 1'b1;
        tick();
        Start = 1'b0;
        if (mode == 1) begin
            FrameBase = $urandom;
            FrameCols = DIM_W'($urandom_range(0, 7));
            WinCols   = DIM_W'($urandom_range(0, 7));
        end

        if (!valid_cfg) begin
            check("inv.PosValid", 32'(PosValid), 0);
            check("inv.Done",     32'(Done), 1);
            check("inv.Err",      32'(Err), 1);
            check("inv.Busy",     32'(Busy), 0);
            tick();
            check("inv.PosValid2", 32'(PosValid), 0);
            check("inv.Done2",     32'(Done), 0);
            check("inv.ErrHold",   32'(Err), 1);
            return;
        end

        idx = 0;
        cycles = 0;
        stall = 0;
        while (idx < n && cycles < 4 * n + 50) begin
            check("pos.PosValid", 32'(PosValid), 1);
            check("pos.Busy",     32'(Busy), 1);
            check("pos.Err",      32'(Err), 0);
            check("pos.Done",     32'(Done), 0);
            check("pos.add4_out", add4_out, exp_addr[idx]);
            check("pos.WinRow",   32'(WinRow), exp_row[idx]);
            check("pos.WinCol",   32'(WinCol), exp_col[idx]);
            check("pos.LastPos",  32'(LastPos), 32'(idx == n - 1));
            if (abort_after != 0 && idx == abort_after) begin
                Rst   = 1'b1;
                Start = 1'b1;
                PosReady = 1'b1;
                tick();
                Rst   = 1'b0;
                Start = 1'b0;
                check_all_zero("abort");
                return;
            end
            case (mode)
                1: begin
                    PosReady = 1'($urandom);
                    Start    = 1'($urandom);
                end
                2: begin
                    if (idx == 1 && stall < 3) begin
                        PosReady = 1'b0;
                        stall++;
                    end else begin
                        PosReady = 1'b1;
                    end
                end
                default: PosReady = 1'b1;
            endcase
            tick();
            cycles++;
            if (PosReady) idx++;
        end
        check("scan.complete", idx, n);
        Start = 1'b0;
        check("done.Done",     32'(Done), 1);
        check("done.PosValid", 32'(PosValid), 0);
        check("done.Busy",     32'(Busy), 0);
        check("done.Err",      32'(Err), 0);
        tick();
        check("idle.Done",     32'(Done), 0);
        check("idle.PosValid", 32'(PosValid), 0);
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b1;
        tick();
        tick();
        Rst   = 1'b0;
        Start = 1'b0;
        check_all_zero("reset");

        run_scan(32'h0000_1000, 4, 4, 2, 2, 0, 0);
        run_scan(32'h0000_1000, 4, 4, 2, 2, 2, 0);
        run_scan(32'h0000_1000, 4, 4, 5, 1, 0, 0);
        run_scan(32'h0000_2000, 4, 4, 4, 4, 0, 0);
        run_scan(32'h0000_1000, 4, 4, 2, 2, 0, 4);
        run_scan(32'h0000_1000, 4, 4, 2, 2, 0, 0);
        run_scan(32'hFFFF_FFF8, 3, 1, 1, 1, 0, 0);
        run_scan(32'h0000_0100, 5, 3, 0, 2, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int unsigned fc, fr, wc, wr;
            fc = $urandom_range(1, 7);
            fr = $urandom_range(1, 6);
            wc = $urandom_range(0, fc + 1);
            wr = $urandom_range(0, fr + 1);
            run_scan($urandom, fc, fr, wc, wr, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/win_pos_gen.md
WIN_POS_GEN -- requirements
Module: win_pos_gen

Interface
REQ-001 SHALL have parameter DIM_W, default 8: width of the frame and window dimension inputs and the row/col outputs.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request a new scan; sampled only in IDLE.
REQ-005 SHALL have port FrameBase  input  32  byte address of frame pixel (0,0).
REQ-006 SHALL have ports FrameCols and FrameRows  input  DIM_W  frame width and height in words.
REQ-007 SHALL have ports WinCols and WinRows  input  DIM_W  window width and height in words.
REQ-008 SHALL have port PosReady  input  1  the downstream 16-way window adder accepts the current position.
REQ-009 SHALL have port PosValid  output  1  add4_out, WinRow, WinCol and LastPos are valid.
REQ-010 SHALL have port add4_out  output  32  byte offset of the window origin; this is the common addend for the 16-way window adder.
REQ-011 SHALL have ports WinRow and WinCol  output  DIM_W  origin row and column of the current window.
REQ-012 SHALL have port LastPos  output  1  the current position is the final one.
REQ-013 SHALL have ports Busy, Done and Err  output  1 each  scan running; one-cycle completion pulse; invalid configuration.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE with Start=1 SHALL capture all config inputs; config input changes after capture SHALL have no effect.
REQ-016 A valid config SHALL go to RUN; PosValid SHALL be 1 in the cycle after the Start edge (1-cycle latency).
REQ-017 A config SHALL be invalid if WinCols=0, WinRows=0, WinCols>FrameCols or WinRows>FrameRows; it SHALL go directly to DONE with Err=1 and PosValid never asserted.
REQ-018 A transfer SHALL occur when PosValid=1 and PosReady=1 in the same cycle; the position SHALL advance only on a transfer.
REQ-019 While PosValid=1 and PosReady=0, all position outputs SHALL hold stable.
REQ-020 Scan order SHALL be raster: WinCol 0..FrameCols-WinCols within a row, then WinRow+1 with WinCol=0; total positions (FrameRows-WinRows+1)*(FrameCols-WinCols+1).
REQ-021 add4_out SHALL equal FrameBase + 4*(WinRow*FrameCols + WinCol), modulo 2^32.
REQ-022 add4_out SHALL be computed incrementally with no multiplier: +4 per column step; on row wrap, a row-start register SHALL add 4*FrameCols and add4_out SHALL load that value.
REQ-023 LastPos SHALL be 1 exactly while the final position is presented.
REQ-024 The transfer of the final position SHALL move the FSM to DONE; DONE SHALL last one cycle with Done=1 and PosValid=0, then return to IDLE.
REQ-025 Busy SHALL be 1 only in RUN; Start SHALL be ignored in RUN and DONE.
REQ-026 Err SHALL hold until the next accepted Start, which SHALL clear it.

Reset
REQ-027 Rst=1 at a clock edge SHALL force IDLE, with PosValid, add4_out, WinRow, WinCol, LastPos, Busy, Done and Err all 0 from the following cycle, regardless of the current state.
REQ-028 Rst SHALL take priority over Start and over transfers in the same cycle.

Verification
REQ-029 FrameBase=0x1000, 4x4 frame, 2x2 window, PosReady=1 -> add4_out 0x1000,0x1004,0x1008,0x1010,0x1014,0x1018,0x1020,0x1024,0x1028; LastPos=1 on the 9th; Done pulses in the next cycle.
REQ-030 Same config, PosReady=0 for 3 cycles while the 2nd position is presented -> add4_out holds 0x1004 and WinCol holds 1; no position is skipped or repeated.
REQ-031 FrameCols=4, WinCols=5 -> Err=1, one Done pulse, PosValid stays 0.
REQ-032 4x4 window on a 4x4 frame -> exactly one position, add4_out=FrameBase, LastPos=1 on it.
REQ-033 Rst asserted after the 4th transfer -> all outputs 0 in the next cycle; a new Start restarts the scan at add4_out=FrameBase.
REQ-034 FrameBase=0xFFFFFFF8, 1x3 frame, 1x1 window -> add4_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap-around).
